// File: rtl/mem_loader.sv
// Byte-stream driven main-memory initiator: loads and dumps words over a byte
// link and holds the CPU pipeline in reset until the host sends a go command.
module mem_loader #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  mem_write,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic                  cpu_rstn
);

  localparam logic [7:0] CMD_W    = 8'h57;
  localparam logic [7:0] CMD_R    = 8'h52;
  localparam logic [7:0] CMD_G    = 8'h47;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_WDATA, S_WSTORE, S_READ, S_LATCH, S_SEND, S_ACK, S_RUN
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  hdr_cnt;
  logic [39:0] hdr_q;      // address bytes 0..3 and count low byte, LE
  logic [15:0] n_q;
  logic [1:0]  byte_cnt;
  logic [31:0] rd_shift;
  logic        is_read;
  logic        is_go;

  logic        rx_fire;
  logic        tx_fire;
  logic [15:0] n_in;
  logic        hdr_last;
  logic        unused_addr_bits;

  assign rx_fire  = rx_valid & rx_ready;
  assign tx_fire  = tx_valid & tx_ready;
  assign n_in     = {rx_data, hdr_q[39:32]};
  assign hdr_last = (hdr_cnt == 3'd5);
  assign unused_addr_bits = ^{hdr_q[1:0], hdr_q[31:ADDR_WIDTH+2]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output and next-state term gets a default before the case so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rx_ready  = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    mem_write = 1'b0;
    cpu_rstn  = 1'b0;
    case (state_q)
      S_IDLE: begin
        rx_ready = 1'b1;
        if (rx_fire) begin
          if (rx_data == CMD_W || rx_data == CMD_R) state_d = S_HDR;
          else if (rx_data == CMD_G)                state_d = S_ACK;
        end
      end
      S_HDR: begin
        rx_ready = 1'b1;
        if (rx_fire && hdr_last) begin
          if (n_in == 16'd0) state_d = is_read ? S_IDLE : S_ACK;
          else               state_d = is_read ? S_READ : S_WDATA;
        end
      end
      S_WDATA: begin
        rx_ready = 1'b1;
        if (rx_fire && byte_cnt == 2'd3) state_d = S_WSTORE;
      end
      S_WSTORE: begin
        mem_write = 1'b1;
        state_d   = (n_q == 16'd1) ? S_ACK : S_WDATA;
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_SEND;
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = rd_shift[7:0];
        if (tx_fire && byte_cnt == 2'd3) state_d = (n_q == 16'd1) ? S_IDLE : S_READ;
      end
      S_ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_fire) state_d = is_go ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        rx_ready = 1'b1;
        cpu_rstn = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_wmask = {4{mem_write}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hdr_cnt   <= '0;
      hdr_q     <= '0;
      n_q       <= '0;
      byte_cnt  <= '0;
      rd_shift  <= '0;
      is_read   <= 1'b0;
      is_go     <= 1'b0;
      mem_wdata <= '0;
      mem_addr  <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (rx_fire) begin
          hdr_cnt <= '0;
          is_read <= (rx_data == CMD_R);
          is_go   <= (rx_data == CMD_G);
        end
        S_HDR: if (rx_fire) begin
          if (hdr_last) begin
            mem_addr <= hdr_q[ADDR_WIDTH+1:2];
            n_q      <= n_in;
            byte_cnt <= '0;
          end else begin
            hdr_q   <= {rx_data, hdr_q[39:8]};
            hdr_cnt <= hdr_cnt + 3'd1;
          end
        end
        S_WDATA: if (rx_fire) begin
          mem_wdata <= {rx_data, mem_wdata[31:8]};
          byte_cnt  <= byte_cnt + 2'd1;
        end
        S_WSTORE: begin
          mem_addr <= mem_addr + ADDR_WIDTH'(1);
          n_q      <= n_q - 16'd1;
        end
        S_LATCH: rd_shift <= mem_rdata;
        S_SEND: if (tx_fire) begin
          rd_shift <= {8'h00, rd_shift[31:8]};
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
            n_q      <= n_q - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: scoreboards for memory writes and
// transmitted bytes, with a behavioural SPRAM model behind the memory port.
module tb_mem_loader;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          mem_write;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          cpu_rstn;

  mem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .cpu_rstn(cpu_rstn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] txq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  bit         stall_en = 1'b0;

  // SPRAM model: read data valid one cycle after the address
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Write scoreboard
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (mem_write) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write addr=%h data=%h", mem_addr, mem_wdata);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if ({mem_addr, mem_wdata, mem_wmask} !== {e.addr, e.data, 4'hF}) begin
            n_err++;
            $display("FAIL write got addr=%h data=%h mask=%h, want addr=%h data=%h mask=f",
                     mem_addr, mem_wdata, mem_wmask, e.addr, e.data);
          end
        end
      end else if (mem_wmask !== 4'h0) begin
        n_cmp++;
        n_err++;
        $display("FAIL idle_wmask got %h want 0", mem_wmask);
      end
    end
  end

  // Transmit scoreboard and stall stability
  logic [7:0] held_byte;
  bit         held = 1'b0;
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (held) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== held_byte) begin
          n_err++;
          $display("FAIL tx_stall_hold got valid=%b data=%h want valid=1 data=%h",
                   tx_valid, tx_data, held_byte);
        end
      end
      held = 1'b0;
      if (tx_valid && tx_ready) begin
        n_cmp++;
        if (txq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_tx got %h", tx_data);
        end else begin
          logic [7:0] e;
          e = txq.pop_front();
          if (tx_data !== e) begin
            n_err++;
            $display("FAIL tx_byte got %h want %h", tx_data, e);
          end
        end
      end else if (tx_valid) begin
        held      = 1'b1;
        held_byte = tx_data;
      end
    end else begin
      held = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    rx_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL rx_accept timeout byte=%h", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                            input logic [15:0] n);
    send_byte(cmd);
    for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_tx_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) txq.push_back(w[8*i +: 8]);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wq.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (wq.size() == 0 && txq.size() == 0) done = 1'b1;
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (!done || wq.size() != 0 || txq.size() != 0) begin
      n_err++;
      $display("FAIL %s drain got pending_wr=%0d pending_tx=%0d want 0/0",
               tag, wq.size(), txq.size());
      wq.delete();
      txq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    n_cmp++;
    if ({rx_ready, tx_valid, tx_data, mem_write, mem_wmask, mem_wdata, mem_addr, cpu_rstn}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0, 14'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values got rdy=%b tv=%b td=%h w=%b m=%h wd=%h a=%h c=%b want 1 0 00 0 0 0 0 0",
               rx_ready, tx_valid, tx_data, mem_write, mem_wmask, mem_wdata, mem_addr, cpu_rstn);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write;
    push_wr(14'h0004, 32'h11223344);
    push_wr(14'h0005, 32'h55667788);
    txq.push_back(8'h4B);
    send_frame(8'h57, 32'h0000_0010, 16'd2);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
    @(negedge clk);
    n_cmp++;
    if ({mem_write, rx_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL write_latency_t1 got write=%b rdy=%b want 1 0", mem_write, rx_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_write, rx_ready, mem_addr} !== {1'b0, 1'b1, 14'h0005}) begin
      n_err++;
      $display("FAIL write_latency_t2 got write=%b rdy=%b addr=%h want 0 1 0005",
               mem_write, rx_ready, mem_addr);
    end
    send_word(32'h55667788);
    wait_drain("write");
  endtask

  task automatic test_read;
    stall_en = 1'b1;
    push_tx_word(32'h11223344);
    push_tx_word(32'h55667788);
    send_frame(8'h52, 32'h0000_0010, 16'd2);
    wait_drain("read");
    stall_en = 1'b0;
  endtask

  task automatic test_wrap;
    push_wr(14'h3FFF, 32'hA1B2C3D4);
    push_wr(14'h0000, 32'h0F1E2D3C);
    txq.push_back(8'h4B);
    send_frame(8'h57, 32'h0000_FFFC, 16'd2);
    send_word(32'hA1B2C3D4);
    send_word(32'h0F1E2D3C);
    wait_drain("wrap_write");
    stall_en = 1'b1;
    push_tx_word(32'hA1B2C3D4);
    push_tx_word(32'h0F1E2D3C);
    send_frame(8'h52, 32'h0000_FFFC, 16'd2);
    wait_drain("wrap_read");
    stall_en = 1'b0;
  endtask

  task automatic test_degenerate;
    txq.push_back(8'h4B);
    send_frame(8'h57, 32'h0000_0030, 16'd0);
    wait_drain("write_n0");
    send_frame(8'h52, 32'h0000_0030, 16'd0);
    wait_drain("read_n0");
    n_cmp++;
    if ({rx_ready, tx_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL read_n0_idle got rdy=%b tv=%b want 1 0", rx_ready, tx_valid);
    end
    send_byte(8'h00);
    push_tx_word(32'h11223344);
    send_frame(8'h52, 32'h0000_0010, 16'd1);
    wait_drain("ignore_byte");
  endtask

  task automatic test_go;
    bit seen = 1'b0;
    txq.push_back(8'h4B);
    send_byte(8'h47);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || cpu_rstn !== 1'b0) begin
      n_err++;
      $display("FAIL go_ack got seen=%b cpu_rstn=%b want 1 0", seen, cpu_rstn);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (cpu_rstn !== 1'b1) begin
      n_err++;
      $display("FAIL go_release got cpu_rstn=%b want 1", cpu_rstn);
    end
    send_frame(8'h57, 32'h0000_0040, 16'd1);
    send_word(32'hCAFEBABE);
    wait_drain("run_discard");
    n_cmp++;
    if ({cpu_rstn, rx_ready, tx_valid} !== 3'b110) begin
      n_err++;
      $display("FAIL run_hold got cpu_rstn=%b rdy=%b tv=%b want 1 1 0",
               cpu_rstn, rx_ready, tx_valid);
    end
  endtask

  task automatic test_midframe_reset;
    send_frame(8'h57, 32'h0000_0020, 16'd1);
    send_byte(8'hDE);
    send_byte(8'hAD);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({rx_ready, tx_valid, tx_data, mem_write, mem_wmask, mem_wdata, mem_addr, cpu_rstn}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 32'h0, 14'h0, 1'b0}) begin
      n_err++;
      $display("FAIL midframe_reset got rdy=%b tv=%b td=%h w=%b m=%h wd=%h a=%h c=%b want 1 0 00 0 0 0 0 0",
               rx_ready, tx_valid, tx_data, mem_write, mem_wmask, mem_wdata, mem_addr, cpu_rstn);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (mem_write !== 1'b0 || cpu_rstn !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold got write=%b cpu_rstn=%b want 0 0", mem_write, cpu_rstn);
      end
    end
    rstn = 1'b1;
    push_wr(14'h0008, 32'h0BADF00D);
    txq.push_back(8'h4B);
    send_frame(8'h57, 32'h0000_0020, 16'd1);
    send_word(32'h0BADF00D);
    wait_drain("after_reset");
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_wrap;
    test_degenerate;
    test_go;
    test_midframe_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_loader.md
# mem_loader

Byte-stream driven memory initiator for the UP5K SoC: it is the other end of the main-memory port and drives the same write/wmask/wdata/addr/rdata interface that the 64KiB SPRAM main memory presents to the pipeline. A host sends it command bytes through the CSR UART byte stream. It writes words into main memory, reads them back onto a transmit byte stream, and holds the CPU in reset until the host issues a go command. The top level muxes main memory to this block while `cpu_rstn` is low.

## Interface
- ADDR_WIDTH, 14, word-address bits of main memory (14 = 64KiB)
- clk  in  1  system clock
- rstn  in  1  asynchronous, active-low reset
- rx_valid  in  1  receive byte available
- rx_data  in  8  receive byte
- rx_ready  out  1  loader accepts byte; transfer when rx_valid & rx_ready
- tx_valid  out  1  transmit byte available
- tx_data  out  8  transmit byte; stable while tx_valid & !tx_ready
- tx_ready  in  1  sink accepts byte; transfer when tx_valid & tx_ready
- mem_write  out  1  one-cycle write strobe
- mem_wmask  out  4  byte enables: 4'b1111 during write, else 0
- mem_wdata  out  32  write data
- mem_addr  out  ADDR_WIDTH  word address, registered
- mem_rdata  in  32  read data, valid one cycle after mem_addr is presented
- cpu_rstn  out  1  pipeline reset: low until a G command completes

## Operation
- Frame: command byte, 4-byte byte address (LE), 2-byte word count N (LE).
- Address handling: address bits [1:0] are ignored. Bits above ADDR_WIDTH+1 are ignored.
- Commands: W = 0x57, R = 0x52, G = 0x47. Any other byte received in IDLE is discarded and the state stays IDLE.
- States: IDLE, HDR, WDATA, WSTORE, READ, LATCH, SEND, ACK, RUN.
- IDLE:
  - W or R moves to HDR. The 6-byte counter is cleared.
  - G moves to ACK, then to RUN.
- HDR: collects 6 bytes. After the 6th byte:
  - W with N=0 goes to ACK.
  - R with N=0 goes to IDLE.
  - W otherwise goes to WDATA.
  - R otherwise goes to READ.
- WDATA: shifts in 4 bytes LE; the first byte is wdata[7:0]. After the 4th byte it goes to WSTORE.
- WSTORE: drives mem_write=1 and mem_wmask=1111 for one cycle. Then mem_addr increments and N decrements. It goes to WDATA if N>0, else to ACK.
- READ: presents mem_addr for one cycle.
- LATCH: captures mem_rdata into a shift register.
- SEND: emits 4 bytes LE. After the 4th transfer, mem_addr increments and N decrements. It goes to READ if N>0, else to IDLE.
- ACK: emits 0x4B. It goes to RUN if entered from G, else to IDLE.
- RUN: cpu_rstn=1. rx_ready=1 and every byte is discarded. It is left only by reset.
- rx_ready is 1 in IDLE, HDR, WDATA and RUN, and 0 elsewhere.
- Address arithmetic: mem_addr increments modulo 2^ADDR_WIDTH (0x3FFF wraps to 0x0000). N is 16-bit unsigned.

## Timing
- Reset values: state IDLE, rx_ready 1, tx_valid 0, tx_data 0, mem_write 0, mem_wmask 0, mem_wdata 0, mem_addr 0, cpu_rstn 0.
- Reset is asynchronous and may occur mid-frame. Outputs take reset values immediately; any partial word is dropped and no write is issued.
- Write latency: the 4th data byte is accepted in cycle t. mem_write is high in t+1 only, and rx_ready is 0 in t+1. mem_addr holds the new value and rx_ready is 1 in t+2.
- Read latency: READ is at cycle t and LATCH at t+1. tx_valid rises at t+2 with byte 0.
- tx_data and tx_valid are held until accepted. The next byte is presented the cycle after a transfer.
- G: 0x4B is transferred in cycle t, and cpu_rstn rises at t+1.

## Test plan
- W at addr 0x00000010, N=2, bytes 44 33 22 11 88 77 66 55 -> mem_write at addr 0x0004 with data 0x11223344, then at 0x0005 with 0x55667788, each with wmask 1111, then tx 0x4B.
- After the previous scenario, R at addr 0x10, N=2 with a memory model and random tx_ready stalls -> tx 44 33 22 11 88 77 66 55, tx_data stable during every stall.
- W at addr 0x0000FFFC, N=2 -> writes at 0x3FFF then 0x0000.
- Degenerate inputs:
  - W with N=0 -> tx 0x4B and no mem_write.
  - R with N=0 -> no tx and returns to IDLE.
  - Byte 0x00 in IDLE -> ignored.
- G -> tx 0x4B, then cpu_rstn=1 one cycle after the transfer. A following byte 0x57 plus a full frame -> no mem_write.
- rstn pulsed low after 2 of 4 W data bytes -> all outputs at reset values during reset and no mem_write. A fresh W frame afterwards completes correctly.
